// File: rtl/apb_pkg.sv
// apb_pkg -- definitions shared by the APB master, its timer and APB benches.
//
// Contents:
//   APB_ADDRW / APB_DATAW : default APB address and data widths
//   apb_state_e           : master FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   cnt_width()           : width of the ACCESS wait counter for a given TIMEOUT

package apb_pkg;

    localparam int APB_ADDRW = 32;
    localparam int APB_DATAW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // The counter must be able to hold TIMEOUT itself; a zero TIMEOUT still
    // gets a 1-bit counter so the port never collapses to zero width.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_timer.sv
// apb_master_timer -- saturating ACCESS wait counter with expiry flag.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-high reset, clears the counter
//   clear  : clears the counter (asserted on the transition into SETUP)
//   inc    : one more ACCESS cycle with PREADY low
//   count  : current number of wait cycles seen in this transfer
//   expire : combinational; high when this increment makes count reach
//            TIMEOUT (never high when TIMEOUT is 0)

module apb_master_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            inc,
    output logic [CNTW-1:0] count,
    output logic            expire
);

    // With the timeout disabled the counter simply saturates at all-ones.
    localparam logic [CNTW-1:0] CNT_MAX = (TIMEOUT == 0) ? {CNTW{1'b1}} : TIMEOUT[CNTW-1:0];
    localparam logic [CNTW:0]   LIMIT   = TIMEOUT[CNTW:0];

    logic [CNTW-1:0] count_q;
    logic [CNTW:0]   count_inc;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Compare the post-increment value one bit wider so the test cannot wrap.
    assign count_inc = {1'b0, count_q} + {{CNTW{1'b0}}, 1'b1};
    assign expire    = (TIMEOUT != 0) && inc && (count_inc >= LIMIT);
    assign count     = count_q;

endmodule

// File: rtl/apb_master.sv
// apb_master -- single-outstanding APB requester with response handshake.
//
// Ports:
//   PCLK, PRESET                 : clock and synchronous active-high reset
//   cmd_valid/cmd_ready          : request handshake; cmd_addr, cmd_write,
//                                  cmd_wdata are captured when both are high
//   rsp_valid/rsp_ready          : response handshake; rsp_rdata, rsp_err
//                                  are held until rsp_ready is seen high
//   PADDR, PSEL, PENABLE,
//   PWRITE, PWDATA               : APB request signals
//   PREADY, PRDATA, PSLVERR      : APB completion signals
//   state, wait_count            : debug view of the FSM and wait counter
//
// Handshake rule: a transfer on either interface happens on a rising edge
// where valid and ready are both high; valid never depends on ready, and a
// response, once valid, holds its payload until taken.

module apb_master
    import apb_pkg::*;
#(
    parameter int ADDRW   = APB_ADDRW,
    parameter int DATAW   = APB_DATAW,
    parameter int TIMEOUT = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ADDRW-1:0]              cmd_addr,
    input  logic                          cmd_write,
    input  logic [DATAW-1:0]              cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATAW-1:0]              rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDRW-1:0]              PADDR,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [DATAW-1:0]              PWDATA,
    input  logic                          PREADY,
    input  logic [DATAW-1:0]              PRDATA,
    input  logic                          PSLVERR,
    output apb_state_e                    state,
    output logic [cnt_width(TIMEOUT)-1:0] wait_count
);

    localparam int CNTW = cnt_width(TIMEOUT);

    apb_state_e       state_q;
    apb_state_e       state_d;
    logic             accept;
    logic             wait_inc;
    logic             expire;
    logic [ADDRW-1:0] paddr_q;
    logic             pwrite_q;
    logic [DATAW-1:0] pwdata_q;
    logic [DATAW-1:0] rdata_q;
    logic             err_q;

    assign accept   = (state_q == IDLE) && cmd_valid;
    assign wait_inc = (state_q == ACCESS) && !PREADY;

    apb_master_timer #(
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) u_timer (
        .clk    (PCLK),
        .rst    (PRESET),
        .clear  (accept),
        .inc    (wait_inc),
        .count  (wait_count),
        .expire (expire)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PREADY is checked before expiry so a slave answering on the last
    // allowed cycle completes normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || expire) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request and response payload registers. The request fields only load
    // in IDLE, so they stay put from SETUP through RESP.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                paddr_q  <= cmd_addr;
                pwrite_q <= cmd_write;
                pwdata_q <= cmd_wdata;
            end
            if (state_q == ACCESS) begin
                if (PREADY) begin
                    rdata_q <= pwrite_q ? '0 : PRDATA;
                    err_q   <= PSLVERR;
                end else if (expire) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = (state_q == ACCESS);
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign state     = state_q;

endmodule
